l2_wb_drain: RTL and testbench
==============================

L2_WB_DRAIN -- requirements
Module: l2_wb_drain

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 32, write data width.
REQ-002 SHALL have parameter TAG_LENGTH, default 30, word-address tag width; mem_addr = {tag, 2'b00}.
REQ-003 SHALL have parameter MAX_RETRY, default 3, error retries per entry before discard.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, response timeout (WB_DRAIN_TIMEOUT_EN only).
REQ-005 SHALL have ports: clk_l2 in 1, single clock; rst_n in 1, reset (synchronous, active-low).
REQ-006 SHALL have ports: wb_data_in in DATA_LENGTH, buffer head data; wb_tag_in in TAG_LENGTH, buffer head tag; wb_empty in 1, buffer empty flag.
REQ-007 SHALL have port wb_load out 1, one-cycle pop strobe to the write buffer.
REQ-008 SHALL have ports: drain_hold in 1, suppress new drains; mem_req_valid out 1; mem_req_ready in 1; mem_addr out TAG_LENGTH+2; mem_wdata out DATA_LENGTH.
REQ-009 SHALL have ports: mem_resp_valid in 1; mem_resp_err in 1, qualified by mem_resp_valid.
REQ-010 SHALL have ports: idle out 1, FSM in IDLE; err_sticky out 1, an entry was discarded; drain_count out 16, entries retired.

Function
REQ-011 SHALL implement states IDLE, FETCH, ISSUE, WAIT_RESP, POP.
REQ-012 IDLE->FETCH SHALL occur when !wb_empty && !drain_hold; otherwise SHALL stay in IDLE.
REQ-013 FETCH SHALL last exactly one cycle, covering the buffer's registered read latency; at its end wb_tag_in/wb_data_in SHALL be captured into internal registers.
REQ-014 ISSUE SHALL drive mem_req_valid=1 with the captured address/data held stable until mem_req_valid && mem_req_ready, then go to WAIT_RESP.
REQ-015 mem_req_valid SHALL NOT deassert in ISSUE before ready is seen; drain_hold SHALL NOT abort ISSUE.
REQ-016 WAIT_RESP on mem_resp_valid && !mem_resp_err SHALL go to POP.
REQ-017 WAIT_RESP on mem_resp_valid && mem_resp_err: if retry_cnt < MAX_RETRY, SHALL increment retry_cnt and return to ISSUE with the same captured data; else SHALL set err_sticky and go to POP.
REQ-018 POP SHALL assert wb_load for exactly one cycle, clear retry_cnt and increment drain_count, then go to FETCH if !wb_empty && !drain_hold, else to IDLE.
REQ-019 drain_count SHALL wrap from 16'hFFFF to 0; the increment SHALL occur on the discard path as well.
REQ-020 wb_load SHALL NOT be asserted in any state other than POP, so the buffer is never underflowed.
REQ-021 A mem_resp_valid arriving outside WAIT_RESP SHALL be ignored.
REQ-022 mem_req_valid SHALL be 0 in IDLE, FETCH, WAIT_RESP and POP.

Reset
REQ-023 On rst_n=0 at a clk_l2 edge: state=IDLE, wb_load=0, mem_req_valid=0, mem_addr=0, mem_wdata=0, retry_cnt=0, err_sticky=0, drain_count=0, idle=1.
REQ-024 Reset mid-transaction SHALL abandon the entry without popping it; the entry is re-drained after reset if the buffer retains it.

Configuration
REQ-025 With WB_DRAIN_TIMEOUT_EN defined, a counter SHALL run in WAIT_RESP and reach TIMEOUT_CYCLES without a response; the timeout SHALL be treated exactly as mem_resp_err (retry or discard).
REQ-026 Without WB_DRAIN_TIMEOUT_EN, no timeout counter SHALL exist and WAIT_RESP SHALL wait indefinitely.

Structure
REQ-027 The drain_state_t enum and the default MAX_RETRY/TIMEOUT_CYCLES constants SHALL reside in RVS192_package.
REQ-028 The timeout counter SHALL be a sub-module, wb_drain_timer (ports clk_l2, rst_n, run, expired), instantiated only under WB_DRAIN_TIMEOUT_EN.

Verification
REQ-029 Reset, then wb_empty=0, head tag 30'h0000_0010, data 32'hDEAD_BEEF, ready=1, OK resp after 2 cycles -> mem_addr=32'h40, mem_wdata=32'hDEADBEEF, one wb_load pulse, drain_count=1.
REQ-030 Ready low for 5 cycles in ISSUE -> valid, addr and data held constant all 5 cycles; handshake occurs on cycle 6.
REQ-031 mem_resp_err on 4 consecutive responses, MAX_RETRY=3 -> 4 requests issued, err_sticky=1, single wb_load, drain_count=1.
REQ-032 3 entries queued, drain_hold raised during the 2nd ISSUE -> 2nd entry completes, FSM returns to IDLE, 3rd entry drained after drain_hold falls.
REQ-033 rst_n low during WAIT_RESP -> all outputs at reset values next cycle, no wb_load; with WB_DRAIN_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response -> reissue after 8 cycles.

Source files
------------

// File: rtl/RVS192_package.sv
// Shared types and default constants for the L2 write-buffer drain engine.
package RVS192_package;

  localparam int unsigned DefMaxRetry      = 3;
  localparam int unsigned DefTimeoutCycles = 255;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWaitResp,
    StPop
  } drain_state_t;

endpackage

// File: rtl/wb_drain_timer.sv
// Response timeout counter for l2_wb_drain; only instantiated when
// WB_DRAIN_TIMEOUT_EN is defined.
module wb_drain_timer
  import RVS192_package::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic clk_l2,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CntW-1:0] r_cnt;

  // Count cycles spent waiting; restart whenever the wait ends or times out.
  always_ff @(posedge clk_l2) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run || expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive waiting cycle.
  assign expired = run && (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/l2_wb_drain.sv
// L2 write-buffer drain engine: pops entries from the write buffer and writes
// them to memory, retrying on error responses and discarding after MAX_RETRY.
// Optional feature macro: WB_DRAIN_TIMEOUT_EN (a missing response is treated
// as an error response after TIMEOUT_CYCLES).
module l2_wb_drain
  import RVS192_package::*;
#(
  parameter int unsigned DATA_LENGTH    = 32,
  parameter int unsigned TAG_LENGTH     = 30,
  parameter int unsigned MAX_RETRY      = DefMaxRetry,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                    clk_l2,
  input  logic                    rst_n,
  input  logic [DATA_LENGTH-1:0]  wb_data_in,
  input  logic [TAG_LENGTH-1:0]   wb_tag_in,
  input  logic                    wb_empty,
  output logic                    wb_load,
  input  logic                    drain_hold,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [TAG_LENGTH+1:0]   mem_addr,
  output logic [DATA_LENGTH-1:0]  mem_wdata,
  input  logic                    mem_resp_valid,
  input  logic                    mem_resp_err,
  output logic                    idle,
  output logic                    err_sticky,
  output logic [15:0]             drain_count
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  drain_state_t            r_state;
  drain_state_t            w_state_d;
  logic [TAG_LENGTH-1:0]   r_tag;
  logic [DATA_LENGTH-1:0]  r_data;
  logic [RetryW-1:0]       r_retry;
  logic                    r_err;
  logic [15:0]             r_count;

  logic w_can_start;
  logic w_timeout;
  logic w_resp_ok;
  logic w_resp_fail;
  logic w_retry;
  logic w_discard;

`ifdef WB_DRAIN_TIMEOUT_EN
  wb_drain_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_l2  (clk_l2),
    .rst_n   (rst_n),
    .run     (r_state == StWaitResp),
    .expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  assign w_can_start = !wb_empty && !drain_hold;
  // A real response wins over a coincident timeout.
  assign w_resp_ok   = mem_resp_valid && !mem_resp_err;
  assign w_resp_fail = (mem_resp_valid && mem_resp_err) || (!mem_resp_valid && w_timeout);

  // Next-state decode plus retry/discard decisions for the datapath.
  always_comb begin
    w_state_d = r_state;
    w_retry   = 1'b0;
    w_discard = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_can_start) w_state_d = StFetch;
      end
      StFetch: begin
        w_state_d = StIssue;
      end
      StIssue: begin
        if (mem_req_ready) w_state_d = StWaitResp;
      end
      StWaitResp: begin
        if (w_resp_ok) begin
          w_state_d = StPop;
        end else if (w_resp_fail) begin
          if (r_retry < RetryW'(MAX_RETRY)) begin
            w_retry   = 1'b1;
            w_state_d = StIssue;
          end else begin
            w_discard = 1'b1;
            w_state_d = StPop;
          end
        end
      end
      StPop: begin
        w_state_d = w_can_start ? StFetch : StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_l2) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Captured entry, retry counter, sticky error and retired-entry counter.
  always_ff @(posedge clk_l2) begin
    if (!rst_n) begin
      r_tag   <= '0;
      r_data  <= '0;
      r_retry <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      // Buffer head is valid at the end of FETCH (registered read).
      if (r_state == StFetch) begin
        r_tag  <= wb_tag_in;
        r_data <= wb_data_in;
      end
      if (w_retry) begin
        r_retry <= r_retry + 1'b1;
      end else if (r_state == StPop) begin
        r_retry <= '0;
      end
      if (w_discard) r_err <= 1'b1;
      if (r_state == StPop) r_count <= r_count + 16'd1;
    end
  end

  assign wb_load       = (r_state == StPop);
  assign mem_req_valid = (r_state == StIssue);
  assign idle          = (r_state == StIdle);
  assign mem_addr      = {r_tag, 2'b00};
  assign mem_wdata     = r_data;
  assign err_sticky    = r_err;
  assign drain_count   = r_count;

endmodule

// File: tb/tb_l2_wb_drain.sv
// Directed self-checking bench for l2_wb_drain with a small write-buffer model.
module tb_l2_wb_drain;

`ifdef WB_DRAIN_TIMEOUT_EN
  localparam int unsigned TbTimeout = 8;
`else
  localparam int unsigned TbTimeout = 255;
`endif

  logic        clk_l2;
  logic        rst_n;
  logic [31:0] wb_data_in;
  logic [29:0] wb_tag_in;
  logic        wb_empty;
  logic        wb_load;
  logic        drain_hold;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic        mem_resp_err;
  logic        idle;
  logic        err_sticky;
  logic [15:0] drain_count;

  // Write-buffer model: 16-entry ring; empty looks ahead past an in-flight pop.
  logic [29:0] tag_mem  [16];
  logic [31:0] data_mem [16];
  logic [3:0]  head;
  logic [3:0]  tail;
  int          pops;
  int          req_hs;
  logic        underflow;

  int n_checks;
  int n_errors;

  l2_wb_drain #(
    .DATA_LENGTH    (32),
    .TAG_LENGTH     (30),
    .MAX_RETRY      (3),
    .TIMEOUT_CYCLES (TbTimeout)
  ) dut (
    .clk_l2         (clk_l2),
    .rst_n          (rst_n),
    .wb_data_in     (wb_data_in),
    .wb_tag_in      (wb_tag_in),
    .wb_empty       (wb_empty),
    .wb_load        (wb_load),
    .drain_hold     (drain_hold),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_err   (mem_resp_err),
    .idle           (idle),
    .err_sticky     (err_sticky),
    .drain_count    (drain_count)
  );

  initial begin
    clk_l2 = 1'b0;
    forever #5 clk_l2 = ~clk_l2;
  end

  assign wb_tag_in  = tag_mem[head];
  assign wb_data_in = data_mem[head];
  assign wb_empty   = (4'(tail - head) == 4'(wb_load));

  initial begin
    head      = '0;
    pops      = 0;
    req_hs    = 0;
    underflow = 1'b0;
  end

  // Pop the head on wb_load; count pops, handshakes and any underflow.
  always @(posedge clk_l2) begin
    if (wb_load) begin
      if (head == tail) underflow <= 1'b1;
      head <= head + 4'd1;
      pops <= pops + 1;
    end
    if (mem_req_valid && mem_req_ready) req_hs <= req_hs + 1;
  end

  task automatic step();
    @(negedge clk_l2);
  endtask

  task automatic push(input logic [29:0] t, input logic [31:0] d);
    tag_mem[tail]  = t;
    data_mem[tail] = d;
    tail           = tail + 4'd1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    tail           = '0;
    rst_n          = 1'b0;
    drain_hold     = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tag_mem[i]  = '0;
      data_mem[i] = '0;
    end

    // Reset state
    step();
    step();
    chk("rst_idle", idle, 1);
    chk("rst_valid", mem_req_valid, 0);
    chk("rst_load", wb_load, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_count", drain_count, 0);
    rst_n = 1'b1;
    step();
    chk("empty_stays_idle", idle, 1);

    // Single entry, OK response two cycles after the handshake
    push(30'h0000_0010, 32'hDEAD_BEEF);
    mem_req_ready = 1'b1;
    step();
    chk("t1_fetch_idle", idle, 0);
    chk("t1_fetch_valid", mem_req_valid, 0);
    step();
    chk("t1_issue_valid", mem_req_valid, 1);
    chk("t1_addr", mem_addr, 32'h40);
    chk("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("t1_wait_valid", mem_req_valid, 0);
    chk("t1_wait_load", wb_load, 0);
    step();
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("t1_pop_load", wb_load, 1);
    step();
    chk("t1_load_once", wb_load, 0);
    chk("t1_count", drain_count, 1);
    chk("t1_pops", pops, 1);
    chk("t1_idle", idle, 1);

    // Back-pressure: ready low for 5 ISSUE cycles; stray responses ignored
    push(30'h0000_0021, 32'h1234_5678);
    mem_req_ready = 1'b0;
    step();
    step();
    for (int k = 1; k <= 5; k++) begin
      chk("t2_hold_valid", mem_req_valid, 1);
      chk("t2_hold_addr", mem_addr, 32'h84);
      chk("t2_hold_wdata", mem_wdata, 32'h1234_5678);
      mem_resp_valid = (k == 2 || k == 3);
      mem_resp_err   = (k == 2 || k == 3);
      step();
    end
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    chk("t2_c6_valid", mem_req_valid, 1);
    chk("t2_c6_hs", req_hs, 1);
    mem_req_ready = 1'b1;
    step();
    chk("t2_wait_valid", mem_req_valid, 0);
    chk("t2_hs", req_hs, 2);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("t2_pop_load", wb_load, 1);
    chk("t2_no_err", err_sticky, 0);
    step();
    chk("t2_count", drain_count, 2);
    chk("t2_idle", idle, 1);

    // Four error responses: three retries then discard
    push(30'h0000_0003, 32'hCAFE_0003);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t3_issue_valid", mem_req_valid, 1);
      chk("t3_addr", mem_addr, 32'hC);
      chk("t3_err_early", err_sticky, 0);
      step();
      chk("t3_wait_valid", mem_req_valid, 0);
      mem_resp_valid = 1'b1;
      mem_resp_err   = 1'b1;
      step();
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
    end
    chk("t3_pop_load", wb_load, 1);
    chk("t3_err", err_sticky, 1);
    chk("t3_hs", req_hs, 6);
    step();
    chk("t3_load_once", wb_load, 0);
    chk("t3_count", drain_count, 3);
    chk("t3_pops", pops, 3);
    chk("t3_idle", idle, 1);

    // Three entries, drain_hold raised during the second ISSUE
    push(30'h0000_0040, 32'hA000_0040);
    push(30'h0000_0041, 32'hA000_0041);
    push(30'h0000_0042, 32'hA000_0042);
    step();
    chk("t4_e1_fetch", idle, 0);
    step();
    chk("t4_e1_addr", mem_addr, 32'h100);
    step();
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("t4_e1_load", wb_load, 1);
    step();
    chk("t4_e2_fetch_valid", mem_req_valid, 0);
    chk("t4_e2_fetch_idle", idle, 0);
    step();
    chk("t4_e2_addr", mem_addr, 32'h104);
    chk("t4_e2_wdata", mem_wdata, 32'hA000_0041);
    drain_hold = 1'b1;
    step();
    chk("t4_e2_wait_valid", mem_req_valid, 0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("t4_e2_load", wb_load, 1);
    step();
    chk("t4_held_idle", idle, 1);
    step();
    step();
    chk("t4_still_idle", idle, 1);
    chk("t4_pending", wb_empty, 0);
    chk("t4_count_held", drain_count, 5);
    drain_hold = 1'b0;
    step();
    chk("t4_e3_fetch", idle, 0);
    step();
    chk("t4_e3_addr", mem_addr, 32'h108);
    step();
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("t4_e3_load", wb_load, 1);
    step();
    chk("t4_count", drain_count, 6);
    chk("t4_idle", idle, 1);
    chk("t4_pops", pops, 6);

    // Reset during WAIT_RESP abandons the entry; it is re-drained afterwards
    push(30'h0000_0055, 32'h5555_AAAA);
    step();
    step();
    chk("t5_addr", mem_addr, 32'h154);
    step();
    chk("t5_wait_valid", mem_req_valid, 0);
    rst_n = 1'b0;
    step();
    chk("t5_rst_idle", idle, 1);
    chk("t5_rst_valid", mem_req_valid, 0);
    chk("t5_rst_load", wb_load, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_wdata", mem_wdata, 0);
    chk("t5_rst_err", err_sticky, 0);
    chk("t5_rst_count", drain_count, 0);
    chk("t5_rst_pops", pops, 6);
    rst_n = 1'b1;
    step();
    chk("t5_refetch", idle, 0);
    step();
    chk("t5_reissue_addr", mem_addr, 32'h154);
    chk("t5_reissue_wdata", mem_wdata, 32'h5555_AAAA);
    step();
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("t5_load", wb_load, 1);
    step();
    chk("t5_count", drain_count, 1);
    chk("t5_pops", pops, 7);
    chk("t5_idle", idle, 1);

`ifdef WB_DRAIN_TIMEOUT_EN
    // No response: reissue after TIMEOUT_CYCLES waiting cycles
    push(30'h0000_0066, 32'h6666_0066);
    step();
    step();
    chk("to_issue", mem_req_valid, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("to_waiting", mem_req_valid, 0);
    end
    step();
    chk("to_reissue", mem_req_valid, 1);
    chk("to_addr", mem_addr, 32'h198);
    step();
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("to_load", wb_load, 1);
    step();
    chk("to_count", drain_count, 2);
    chk("to_err", err_sticky, 0);
`endif

    chk("no_underflow", underflow, 0);
    chk("buffer_drained", wb_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
